hist_bin_accumulator: RTL and testbench

Histogram bin store and read-modify-write incrementer. It sits downstream of the address sweeper: it consumes the sweeper's addr/addr_valid/wreq outputs to zero every bin, then counts incoming pixel values into COLOR_RANGE bins. A separate read port returns bin counts for readout.

---
 rtl/hist_bin_accumulator_if.sv | 29 ++
 rtl/hist_bin_accumulator.sv | 143 ++++++++++++++
 tb/tb_hist_bin_accumulator.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_bin_accumulator_if.sv
// Pixel stream, clear-sweep and readout signals of the histogram bin accumulator.
// The master side drives pixels, clears and read requests; the slave side is the bin store.
interface hist_bin_accumulator_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int COUNT_WIDTH   = 20
);
   logic                     pix_valid;
   logic [ADDRESS_WIDTH-1:0] pix_data;
   logic [ADDRESS_WIDTH-1:0] clr_addr;
   logic                     clr_addr_valid;
   logic                     clr_wreq;
   logic                     rd_en;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic [COUNT_WIDTH-1:0]   rd_data;
   logic                     rd_valid;
   logic                     busy;
   logic                     overflow;
   logic                     drop_err;

   modport master (
      output pix_valid, pix_data, clr_addr, clr_addr_valid, clr_wreq, rd_en, rd_addr,
      input  rd_data, rd_valid, busy, overflow, drop_err
   );

   modport slave (
      input  pix_valid, pix_data, clr_addr, clr_addr_valid, clr_wreq, rd_en, rd_addr,
      output rd_data, rd_valid, busy, overflow, drop_err
   );
endinterface

// File: rtl/hist_bin_accumulator.sv
// Histogram bin store: sweep-driven clearing, a two-stage saturating
// read-modify-write incrementer with forwarding, and a registered readout port.
module hist_bin_accumulator #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int COLOR_RANGE   = 256,
   parameter int COUNT_WIDTH   = 20
) (
   input  logic                  clk,
   input  logic                  arstn,
   hist_bin_accumulator_if.slave bus
);
   typedef logic [ADDRESS_WIDTH-1:0] bin_t;
   typedef logic [COUNT_WIDTH-1:0]   cnt_t;

   localparam logic [ADDRESS_WIDTH:0] RANGE_LIM = (ADDRESS_WIDTH+1)'(COLOR_RANGE);
   localparam cnt_t                   CNT_MAX   = '1;

   cnt_t mem_q [COLOR_RANGE];

   // S1: accepted pixel and its registered RAM read
   logic s1_valid_q;
   bin_t s1_bin_q;
   cnt_t s1_rdata_q;
   // S2: incremented value waiting for its write edge
   logic s2_valid_q;
   bin_t s2_bin_q;
   cnt_t s2_wdata_q;
   logic s2_sat_q;
   // Last value written by the increment path
   logic fwd_valid_q;
   bin_t fwd_bin_q;
   cnt_t fwd_data_q;

   cnt_t rd_data_q;
   logic rd_valid_q;
   logic overflow_q, overflow_d;
   logic drop_err_q, drop_err_d;

   logic clr_hit, pix_in_range, pix_accept, pix_drop, inc_we, rd_in_range;
   cnt_t base_d, s2_wdata_d;
   logic s2_sat_d;

   always_comb begin
      clr_hit      = bus.clr_wreq & bus.clr_addr_valid & ({1'b0, bus.clr_addr} < RANGE_LIM);
      pix_in_range = {1'b0, bus.pix_data} < RANGE_LIM;
      pix_accept   = bus.pix_valid & ~bus.clr_wreq & pix_in_range;
      pix_drop     = bus.pix_valid & (bus.clr_wreq | ~pix_in_range);
      inc_we       = s2_valid_q & ~clr_hit;
      rd_in_range  = {1'b0, bus.rd_addr} < RANGE_LIM;
   end

   // The S1 RAM read can miss up to two newer values of the same bin: the
   // clear or S2 write landing on this edge, or the write made one edge ago.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      base_d = s1_rdata_q;
      if (clr_hit && (bus.clr_addr == s1_bin_q)) begin
         base_d = '0;
      end else if (inc_we && (s2_bin_q == s1_bin_q)) begin
         base_d = s2_wdata_q;
      end else if (fwd_valid_q && (fwd_bin_q == s1_bin_q)) begin
         base_d = fwd_data_q;
      end
      s2_sat_d   = (base_d == CNT_MAX);
      s2_wdata_d = s2_sat_d ? base_d : base_d + COUNT_WIDTH'(1);
   end

   // Setting a sticky flag wins over a clear at addr 0 on the same edge.
   always_comb begin
      overflow_d = overflow_q;
      drop_err_d = drop_err_q;
      if (clr_hit && (bus.clr_addr == '0)) begin
         overflow_d = 1'b0;
         drop_err_d = 1'b0;
      end
      if (inc_we && s2_sat_q) overflow_d = 1'b1;
      if (pix_drop)           drop_err_d = 1'b1;
   end

   // NOTE: the bin array is deliberately left out of reset; a clear sweep defines it.
   always_ff @(posedge clk) begin
      if (clr_hit) begin
         mem_q[bus.clr_addr] <= '0;
      end else if (inc_we) begin
         mem_q[s2_bin_q] <= s2_wdata_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         s1_valid_q  <= 1'b0;
         s1_bin_q    <= '0;
         s1_rdata_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_bin_q    <= '0;
         s2_wdata_q  <= '0;
         s2_sat_q    <= 1'b0;
         fwd_valid_q <= 1'b0;
         fwd_bin_q   <= '0;
         fwd_data_q  <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         s1_valid_q <= pix_accept;
         if (pix_accept) begin
            s1_bin_q   <= bus.pix_data;
            s1_rdata_q <= mem_q[bus.pix_data];
         end

         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_bin_q   <= s1_bin_q;
            s2_wdata_q <= s2_wdata_d;
            s2_sat_q   <= s2_sat_d;
         end

         if (clr_hit) begin
            fwd_valid_q <= 1'b0;
         end else if (inc_we) begin
            fwd_valid_q <= 1'b1;
            fwd_bin_q   <= s2_bin_q;
            fwd_data_q  <= s2_wdata_q;
         end

         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_q <= rd_in_range ? mem_q[bus.rd_addr] : '0;
         end

         overflow_q <= overflow_d;
         drop_err_q <= drop_err_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = s1_valid_q | s2_valid_q;
   assign bus.overflow = overflow_q;
   assign bus.drop_err = drop_err_q;
endmodule

// File: tb/tb_hist_bin_accumulator.sv
// Directed bench for hist_bin_accumulator: a bin-count model (pixels land two
// edges after acceptance) checked every cycle, plus hand-computed expectations.
module tb_hist_bin_accumulator;
   localparam int AW   = 8;
   localparam int CR   = 240;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   hist_bin_accumulator_if #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

   hist_bin_accumulator #(
      .ADDRESS_WIDTH(AW),
      .COLOR_RANGE  (CR),
      .COUNT_WIDTH  (CW)
   ) dut (
      .clk  (clk),
      .arstn(arstn),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int bin; int due; } pend_t;
   pend_t pend_q[$];
   int    model_ram [256];
   int    cyc = 0;
   int    exp_rd_data = 0;
   bit    exp_rd_valid = 1'b0, exp_ovf = 1'b0, exp_drop = 1'b0;
   bit    clr_w;

   always @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         pend_q.delete();
         exp_rd_data  = 0;
         exp_rd_valid = 1'b0;
         exp_ovf      = 1'b0;
         exp_drop     = 1'b0;
      end else begin
         clr_w = bus.clr_wreq && bus.clr_addr_valid && (int'(bus.clr_addr) < CR);
         // Readout sees the bin contents from before this edge
         exp_rd_valid = bus.rd_en;
         if (bus.rd_en) exp_rd_data = (int'(bus.rd_addr) < CR) ? model_ram[int'(bus.rd_addr)] : 0;
         if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            if (!clr_w) begin
               if (model_ram[pend_q[0].bin] == CMAX) exp_ovf = 1'b1;
               else model_ram[pend_q[0].bin]++;
            end
            void'(pend_q.pop_front());
         end
         if (clr_w) begin
            model_ram[int'(bus.clr_addr)] = 0;
            if (bus.clr_addr == '0) begin
               exp_ovf  = 1'b0;
               exp_drop = 1'b0;
            end
         end
         if (bus.pix_valid) begin
            if (bus.clr_wreq || int'(bus.pix_data) >= CR) exp_drop = 1'b1;
            else pend_q.push_back('{bin: int'(bus.pix_data), due: cyc + 2});
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (arstn && cmp_en) begin
         check("rd_valid", bus.rd_valid, exp_rd_valid);
         check("rd_data",  bus.rd_data,  exp_rd_data);
         check("busy",     bus.busy,     pend_q.size() != 0);
         check("overflow", bus.overflow, exp_ovf);
         check("drop_err", bus.drop_err, exp_drop);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.pix_valid      = 1'b0;
      bus.pix_data       = '0;
      bus.clr_addr       = '0;
      bus.clr_addr_valid = 1'b0;
      bus.clr_wreq       = 1'b0;
      bus.rd_en          = 1'b0;
      bus.rd_addr        = '0;
   endtask

   task automatic do_clear(input int a);
      bus.clr_addr = AW'(a); bus.clr_addr_valid = 1'b1; bus.clr_wreq = 1'b1;
      tick();
      bus.clr_addr_valid = 1'b0; bus.clr_wreq = 1'b0;
   endtask

   task automatic sweep();
      for (int a = 0; a < 256; a++) do_clear(a);
   endtask

   task automatic push_pix(input int v);
      bus.pix_valid = 1'b1; bus.pix_data = AW'(v);
      tick();
      bus.pix_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic read_expect(input string name, input int a, input int exp);
      bus.rd_en = 1'b1; bus.rd_addr = AW'(a);
      tick();
      bus.rd_en = 1'b0;
      check({name, "_vld"}, bus.rd_valid, 1);
      check(name, bus.rd_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd_data",  bus.rd_data,  0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_busy",     bus.busy,     0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_drop_err", bus.drop_err, 0);
      arstn  = 1'b1;
      cmp_en = 1'b1;

      // 1: full sweep, then every bin (including out-of-range ones) reads 0
      sweep();
      for (int a = 0; a < 256; a++) read_expect("sweep_bin", a, 0);
      tick();
      check("t1_rd_valid_drop", bus.rd_valid, 0);
      check("t1_overflow", bus.overflow, 0);
      check("t1_drop_err", bus.drop_err, 0);

      // 2: ten back-to-back pixels of 7, busy window
      push_pix(7);
      check("t2_busy_first", bus.busy, 1);
      for (int i = 0; i < 9; i++) push_pix(7);
      check("t2_busy_last0", bus.busy, 1);
      tick();
      check("t2_busy_last1", bus.busy, 1);
      tick();
      check("t2_busy_last2", bus.busy, 0);
      tick();
      read_expect("t2_bin7", 7, 10);
      read_expect("t2_bin6", 6, 0);
      read_expect("t2_bin8", 8, 0);

      // 3: forwarding and non-adjacent reuse
      push_pix(3); push_pix(3); push_pix(5); push_pix(3); push_pix(5); push_pix(5);
      idle(3);
      read_expect("t3_bin3", 3, 3);
      read_expect("t3_bin5", 5, 3);

      // 4: saturation at 15, overflow sticky until a clear of bin 0
      for (int i = 0; i < 17; i++) push_pix(1);
      idle(3);
      check("t4_overflow_set", bus.overflow, 1);
      read_expect("t4_bin1", 1, 15);
      do_clear(0);
      check("t4_overflow_clr", bus.overflow, 0);

      // 5: pixel during clear dropped; increment colliding with clear discarded
      bus.pix_valid = 1'b1; bus.pix_data = 8'd9;
      bus.clr_addr = 8'd100; bus.clr_addr_valid = 1'b1; bus.clr_wreq = 1'b1;
      tick();
      set_idle();
      check("t5_drop_set", bus.drop_err, 1);
      idle(2);
      read_expect("t5_bin9_a", 9, 0);
      do_clear(0);
      check("t5_drop_clr", bus.drop_err, 0);
      push_pix(9);
      tick();
      do_clear(50);
      idle(2);
      read_expect("t5_bin9_b", 9, 0);
      push_pix(4); push_pix(4);
      do_clear(4);
      idle(2);
      read_expect("t5_bin4", 4, 1);
      push_pix(245);
      check("t5_drop_range", bus.drop_err, 1);
      idle(2);
      read_expect("t5_bin245", 245, 0);

      // 6: asynchronous reset with pixels in flight and a read completing
      push_pix(1);
      push_pix(250);
      idle(1);
      bus.pix_valid = 1'b1; bus.pix_data = 8'd5;
      bus.rd_en = 1'b1; bus.rd_addr = 8'd7;
      tick();
      set_idle();
      check("t6_pre_rd_valid", bus.rd_valid, 1);
      check("t6_pre_rd_data",  bus.rd_data,  10);
      check("t6_pre_busy",     bus.busy,     1);
      check("t6_pre_overflow", bus.overflow, 1);
      check("t6_pre_drop_err", bus.drop_err, 1);
      #1 arstn = 1'b0;
      #1;
      check("t6_rst_rd_valid", bus.rd_valid, 0);
      check("t6_rst_rd_data",  bus.rd_data,  0);
      check("t6_rst_busy",     bus.busy,     0);
      check("t6_rst_overflow", bus.overflow, 0);
      check("t6_rst_drop_err", bus.drop_err, 0);
      idle(2);
      arstn = 1'b1;
      sweep();
      push_pix(200);
      idle(3);
      read_expect("t6_bin200", 200, 1);
      read_expect("t6_bin5", 5, 0);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
